// File: rtl/i2s_rx_stereo_param.sv
// Parametrised stereo I2S / left-justified receiver, fully in the mclk domain.
// Oversamples sclk/lrclk/sdin and emits one aligned L/R pair per frame.
module i2s_rx_chan #(
  parameter int DATA_WIDTH = 24,
  parameter int IW         = 5
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic                  cap,
  input  logic                  last,
  input  logic [IW-1:0]         idx,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  full
);
  // Bits land at their final position, so a short slot leaves zero LSBs.
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      sample <= '0;
      full   <= 1'b0;
    end else if (en) begin
      if (start) begin
        sample <= '0;
        full   <= 1'b0;
      end
      if (cap) begin
        sample[idx] <= sd;
        if (last) full <= 1'b1;
      end
    end
endmodule

module i2s_rx_stereo_param #(
  parameter int DATA_WIDTH   = 24,
  parameter int OUT_WIDTH    = 24,
  parameter int MODE         = 0,
  parameter int MAX_SLOT     = 32,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    lrclk,
  input  logic                    sdin,
  input  logic                    mute_l,
  input  logic                    mute_r,
  output logic [OUT_WIDTH-1:0]    ldata,
  output logic [OUT_WIDTH-1:0]    rdata,
  output logic                    dvalid,
  output logic                    led_l,
  output logic                    led_r,
  output logic                    frame_err,
  output logic [ERRCNT_WIDTH-1:0] err_cnt
);
  localparam int OFF = (MODE == 0) ? 1 : 0;
  localparam int KW  = $clog2(MAX_SLOT + 1);
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0] sclk_s, ws_s, sd_s;
  logic       sclk_d, e_q, ws_e, sd_e;

  // ws/sd are registered alongside the edge flag so they line up with E.
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      sclk_s <= '0; ws_s <= '0; sd_s <= '0;
      sclk_d <= 1'b0; e_q <= 1'b0; ws_e <= 1'b0; sd_e <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      ws_s   <= {ws_s[0], lrclk};
      sd_s   <= {sd_s[0], sdin};
      sclk_d <= sclk_s[1];
      e_q    <= sclk_s[1] & ~sclk_d;
      ws_e   <= ws_s[1];
      sd_e   <= sd_s[1];
    end

  logic                            ws_prev, armed, slot_act, left_ok;
  logic [KW-1:0]                   k, k_nxt;
  logic                            bnd, cap, last, frame_done, short_hit;
  logic [IW-1:0]                   idx;
  logic [1:0][DATA_WIDTH-1:0]      sh;
  logic [1:0]                      full;
  logic                            mute_l_q, mute_r_q;

  always_comb begin
    bnd        = e_q && (ws_e != ws_prev);
    k_nxt      = bnd ? '0 : (k == KW'(MAX_SLOT)) ? k : k + KW'(1);
    cap        = (int'(k_nxt) >= OFF) && (int'(k_nxt) < DATA_WIDTH + OFF);
    last       = (int'(k_nxt) == DATA_WIDTH - 1 + OFF);
    idx        = IW'(DATA_WIDTH - 1 + OFF - int'(k_nxt));
    frame_done = bnd && ws_prev && slot_act && left_ok;
    short_hit  = bnd && slot_act && !full[ws_prev];
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    i2s_rx_chan #(.DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_ch (
      .mclk  (mclk),
      .rst_n (rst_n),
      .en    (e_q && (ws_e == 1'(c))),
      .start (bnd),
      .cap   (cap),
      .last  (last),
      .idx   (idx),
      .sd    (sd_e),
      .sample(sh[c]),
      .full  (full[c])
    );
  end

  // A slot only counts once an earlier edge has been seen since reset;
  // this discards the partial slot running when reset is released.
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      k <= '0; ws_prev <= 1'b1; armed <= 1'b0; slot_act <= 1'b0; left_ok <= 1'b0;
    end else if (e_q) begin
      k       <= k_nxt;
      ws_prev <= ws_e;
      armed   <= 1'b1;
      if (bnd) begin
        slot_act <= armed;
        if (!ws_prev && slot_act) left_ok <= 1'b1;
      end
    end

  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      ldata <= '0; rdata <= '0; dvalid <= 1'b0; frame_err <= 1'b0;
      err_cnt <= '0; mute_l_q <= 1'b0; mute_r_q <= 1'b0;
    end else begin
      mute_l_q  <= mute_l;
      mute_r_q  <= mute_r;
      dvalid    <= frame_done;
      frame_err <= short_hit;
      if (frame_done) begin
        ldata <= mute_l_q ? '0 : OUT_WIDTH'($signed(sh[0]));
        rdata <= mute_r_q ? '0 : OUT_WIDTH'($signed(sh[1]));
      end
      if (short_hit && (err_cnt != '1)) err_cnt <= err_cnt + ERRCNT_WIDTH'(1);
    end

  assign led_l = mute_l_q;
  assign led_r = mute_r_q;
endmodule

// File: tb/tb_i2s_rx_stereo_param.sv
// Directed bench: three receiver configurations share one serial stream.
module tb_i2s_rx_stereo_param;
  logic mclk = 1'b0, rst_n = 1'b0, sclk = 1'b0, lrclk = 1'b1, sdin = 1'b0;
  logic mute_l = 1'b0, mute_r = 1'b0;
  always #5 mclk = ~mclk;

  logic [23:0] ld0, rd0, ld2, rd2;
  logic [31:0] ld1, rd1;
  logic        dv0, dv1, dv2, fe0, fe1, fe2, ll0, lr0, ll1, lr1, ll2, lr2;
  logic [7:0]  ec0, ec2;
  logic [1:0]  ec1;

  i2s_rx_stereo_param u_d0 (
    .mclk(mclk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
    .mute_l(mute_l), .mute_r(mute_r), .ldata(ld0), .rdata(rd0), .dvalid(dv0),
    .led_l(ll0), .led_r(lr0), .frame_err(fe0), .err_cnt(ec0));
  i2s_rx_stereo_param #(.OUT_WIDTH(32), .ERRCNT_WIDTH(2)) u_d1 (
    .mclk(mclk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
    .mute_l(mute_l), .mute_r(mute_r), .ldata(ld1), .rdata(rd1), .dvalid(dv1),
    .led_l(ll1), .led_r(lr1), .frame_err(fe1), .err_cnt(ec1));
  i2s_rx_stereo_param #(.MODE(1)) u_d2 (
    .mclk(mclk), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
    .mute_l(mute_l), .mute_r(mute_r), .ldata(ld2), .rdata(rd2), .dvalid(dv2),
    .led_l(ll2), .led_r(lr2), .frame_err(fe2), .err_cnt(ec2));

  int nv0 = 0, nv1 = 0, nv2 = 0, nf0 = 0, nf1 = 0, nf2 = 0;
  always @(negedge mclk) begin
    if (dv0) nv0++;
    if (dv1) nv1++;
    if (dv2) nv2++;
    if (fe0) nf0++;
    if (fe1) nf1++;
    if (fe2) nf2++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic ws, input logic b);
    @(negedge mclk);
    sclk = 1'b0; lrclk = ws; sdin = b;
    repeat (3) @(negedge mclk);
    sclk = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  task automatic send_slot(input logic ws, input logic [23:0] v, input int off,
                           input int len, input int first, input int last);
    for (int i = first; i < last; i++) begin
      int d;
      d = i - off;
      send_bit(ws, (d >= 0 && d < 24 && d < len) ? v[23-d] : 1'b0);
    end
  endtask

  // First bit of the next left slot; returns mclk edges from sclk rise to dvalid.
  task automatic close_frame(output int lat);
    @(negedge mclk);
    sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    repeat (3) @(negedge mclk);
    sclk = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge mclk);
      if (dv0 && lat < 0) lat = i;
    end
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst_n = 1'b0; sclk = 1'b0; lrclk = 1'b1; sdin = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (2) @(negedge mclk);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  typedef struct {
    logic [23:0] l, r;
    int          len, off, nfr;
    logic [31:0] e0l, e0r, e1l, e1r, e2l, e2r;
    int          err0, err2, ec1;
  } vec_t;

  initial begin
    vec_t tv [4];
    int   lat, b0, b1, b2, f0, f1, f2;
    tv[0] = '{24'h00C491, 24'hFFFFFF, 32, 1, 2, 32'h00C491, 32'hFFFFFF,
              32'h0000C491, 32'hFFFFFFFF, 32'h006248, 32'h7FFFFF, 0, 0, 0};
    tv[1] = '{24'h800001, 24'h000000, 32, 1, 1, 32'h800001, 32'h000000,
              32'hFF800001, 32'h00000000, 32'h400000, 32'h000000, 0, 0, 0};
    tv[2] = '{24'h0085C5, 24'h123456, 24, 0, 2, 32'h010B8A, 32'h2468AC,
              32'h00010B8A, 32'h002468AC, 32'h0085C5, 32'h123456, 4, 0, 3};
    tv[3] = '{24'hABCDEF, 24'h123456, 16, 1, 3, 32'hABCC00, 32'h123400,
              32'hFFABCC00, 32'h00123400, 32'h55E600, 32'h091A00, 6, 6, 3};

    repeat (3) @(negedge mclk);
    chk("rst_ldata", 32'(ld0), 32'h0);
    chk("rst_rdata", 32'(rd0), 32'h0);
    chk("rst_dvalid", 32'(dv0), 32'h0);
    chk("rst_frame_err", 32'(fe0), 32'h0);
    chk("rst_err_cnt", 32'(ec0), 32'h0);
    chk("rst_led_l", 32'(ll0), 32'h0);
    chk("rst_led_r", 32'(lr0), 32'h0);
    chk("rst_ldata_w32", ld1, 32'h0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      b0 = nv0; b1 = nv1; b2 = nv2; f0 = nf0; f1 = nf1; f2 = nf2;
      for (int f = 0; f < tv[v].nfr; f++) begin
        send_slot(1'b0, tv[v].l, tv[v].off, tv[v].len, 0, tv[v].len);
        send_slot(1'b1, tv[v].r, tv[v].off, tv[v].len, 0, tv[v].len);
      end
      close_frame(lat);
      repeat (4) @(negedge mclk);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd4);
      chk($sformatf("v%0d_d0_ldata", v), 32'(ld0), tv[v].e0l);
      chk($sformatf("v%0d_d0_rdata", v), 32'(rd0), tv[v].e0r);
      chk($sformatf("v%0d_d1_ldata", v), ld1, tv[v].e1l);
      chk($sformatf("v%0d_d1_rdata", v), rd1, tv[v].e1r);
      chk($sformatf("v%0d_d2_ldata", v), 32'(ld2), tv[v].e2l);
      chk($sformatf("v%0d_d2_rdata", v), 32'(rd2), tv[v].e2r);
      chk($sformatf("v%0d_d0_dvalids", v), 32'(nv0 - b0), 32'(tv[v].nfr));
      chk($sformatf("v%0d_d1_dvalids", v), 32'(nv1 - b1), 32'(tv[v].nfr));
      chk($sformatf("v%0d_d2_dvalids", v), 32'(nv2 - b2), 32'(tv[v].nfr));
      chk($sformatf("v%0d_d0_ferr", v), 32'(nf0 - f0), 32'(tv[v].err0));
      chk($sformatf("v%0d_d1_ferr", v), 32'(nf1 - f1), 32'(tv[v].err0));
      chk($sformatf("v%0d_d2_ferr", v), 32'(nf2 - f2), 32'(tv[v].err2));
      chk($sformatf("v%0d_d0_errcnt", v), 32'(ec0), 32'(tv[v].err0));
      chk($sformatf("v%0d_d1_errcnt", v), 32'(ec1), 32'(tv[v].ec1));
      chk($sformatf("v%0d_d2_errcnt", v), 32'(ec2), 32'(tv[v].err2));
    end

    // Reset pulse in the middle of a left slot.
    do_reset();
    send_slot(1'b0, 24'h111111, 1, 32, 0, 32);
    send_slot(1'b1, 24'h222222, 1, 32, 0, 32);
    send_slot(1'b0, 24'h333333, 1, 32, 0, 12);
    chk("mid_pre_ldata", 32'(ld0), 32'h111111);
    @(negedge mclk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_ldata", 32'(ld0), 32'h0);
    chk("mid_async_rdata", 32'(rd0), 32'h0);
    @(negedge mclk);
    rst_n = 1'b1;
    b0 = nv0; f0 = nf0;
    send_slot(1'b0, 24'h333333, 1, 32, 12, 32);
    send_slot(1'b1, 24'h444444, 1, 32, 0, 32);
    chk("mid_no_early_dvalid", 32'(nv0 - b0), 32'd0);
    send_slot(1'b0, 24'h555555, 1, 32, 0, 32);
    send_slot(1'b1, 24'h666666, 1, 32, 0, 32);
    close_frame(lat);
    repeat (4) @(negedge mclk);
    chk("mid_dvalids", 32'(nv0 - b0), 32'd1);
    chk("mid_ldata", 32'(ld0), 32'h555555);
    chk("mid_rdata", 32'(rd0), 32'h666666);
    chk("mid_ferr", 32'(nf0 - f0), 32'd0);

    // Mute: led delay, held value untouched, next frame muted, then released.
    do_reset();
    b0 = nv0;
    send_slot(1'b0, 24'h7FFFFF, 1, 32, 0, 32);
    send_slot(1'b1, 24'h000123, 1, 32, 0, 32);
    close_frame(lat);
    repeat (4) @(negedge mclk);
    chk("mute_pre_ldata", 32'(ld0), 32'h7FFFFF);
    mute_l = 1'b1;
    #1;
    chk("mute_led_l_same_cycle", 32'(ll0), 32'h0);
    @(negedge mclk);
    chk("mute_led_l_next_cycle", 32'(ll0), 32'h1);
    repeat (5) @(negedge mclk);
    chk("mute_held_ldata", 32'(ld0), 32'h7FFFFF);
    send_slot(1'b0, 24'h7FFFFF, 1, 32, 1, 32);
    send_slot(1'b1, 24'h000456, 1, 32, 0, 32);
    close_frame(lat);
    repeat (4) @(negedge mclk);
    chk("mute_ldata", 32'(ld0), 32'h0);
    chk("mute_rdata", 32'(rd0), 32'h000456);
    chk("mute_led_r", 32'(lr0), 32'h0);
    mute_l = 1'b0;
    repeat (2) @(negedge mclk);
    chk("unmute_led_l", 32'(ll0), 32'h0);
    send_slot(1'b0, 24'h7FFFFF, 1, 32, 1, 32);
    send_slot(1'b1, 24'h000789, 1, 32, 0, 32);
    close_frame(lat);
    repeat (4) @(negedge mclk);
    chk("unmute_ldata", 32'(ld0), 32'h7FFFFF);
    chk("unmute_rdata", 32'(rd0), 32'h000789);
    chk("mute_dvalids", 32'(nv0 - b0), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_rx_stereo_param.md
Name: i2s_rx_stereo_param

Overview:
- Parametrised successor to the fixed 24-bit stereo I2S receiver. Runs entirely in the mclk domain and oversamples sclk, lrclk and sdin.
- Supports configurable sample width, output sign extension, I2S or left-justified framing, per-channel mute and framing-error detection.
- Sits between the codec serial port and the effects pipeline. Delivers one aligned left/right pair per frame with a single-cycle valid strobe.

Parameters:
DATA_WIDTH, 24, serial sample bits captured per channel slot (8..32)
OUT_WIDTH, 24, width of ldata/rdata; sample is sign-extended from DATA_WIDTH (OUT_WIDTH >= DATA_WIDTH)
MODE, 0, 0 = I2S (MSB one sclk after lrclk edge), 1 = left-justified (MSB on lrclk edge)
MAX_SLOT, 32, maximum expected sclk periods per slot; sizes bit counter (saturates at MAX_SLOT)
ERRCNT_WIDTH, 8, width of saturating frame-error counter

Ports:
mclk  in  1  system clock; must be >= 4x sclk frequency
rst_n  in  1  asynchronous active-low reset
sclk  in  1  serial bit clock (asynchronous to mclk, synchronised internally)
lrclk  in  1  word select; 0 = left slot, 1 = right slot
sdin  in  1  serial data, MSB first
mute_l  in  1  forces left output to zero while high
mute_r  in  1  forces right output to zero while high
ldata  out  OUT_WIDTH  last complete left sample
rdata  out  OUT_WIDTH  last complete right sample
dvalid  out  1  one-cycle strobe: new ldata/rdata pair valid
led_l  out  1  mirrors registered mute_l
led_r  out  1  mirrors registered mute_r
frame_err  out  1  one-cycle strobe on short slot
err_cnt  out  ERRCNT_WIDTH  saturating count of frame_err strobes

Behaviour:
- Reset (rst_n low, async): ldata = rdata = 0, dvalid = 0, frame_err = 0, err_cnt = 0, led_l = led_r = 0. Sync flops, shift registers and bit counter clear. Internal ws_prev = 1, so the first frame starts at the first left slot.
- Synchronisation: sclk, lrclk and sdin each pass through 2 flops. Event E occurs in the mclk cycle where synced sclk is 1 and was 0 the previous cycle. ws and sd are sampled only at E.
- Slot boundary: at E with ws != ws_prev, the bit counter k is set to 0 for the new slot and the previous slot is closed. Otherwise k increments, saturating at MAX_SLOT.
- Capture: data index d = k - (MODE==0 ? 1 : 0).
  - Bits with 0 <= d < DATA_WIDTH shift MSB-first into the shift register of the current channel (ws=0 left, ws=1 right).
  - All other bits are ignored, including the I2S delay bit at k=0.
- Short slot: a slot that closes with fewer than DATA_WIDTH captured bits is a short slot.
  - frame_err pulses in cycle E+1 and err_cnt increments (saturating at all-ones).
  - The missing LSBs are zero.
- Frame complete: at a boundary E with ws_prev=1 and ws=0 (right slot closes):
  - In cycle E+1, ldata/rdata load the sign-extended left/right shift registers (or 0 if the respective mute is high at E).
  - dvalid = 1 in cycle E+1 only.
  - Outputs hold until the next frame.
  - A left slot closing (0->1) produces no dvalid.
- First frame after reset: a right slot without a preceding complete left slot after reset produces no dvalid. The first dvalid follows the first complete left+right pair.
- Sign extension: out = {(OUT_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}, sample}.
- Mute: registered every mclk. led_l/led_r follow one cycle later. Muting affects only samples loaded after assertion; already-held outputs are not cleared.
- Reset mid-frame: partial slot is discarded. No dvalid and no frame_err is generated for it.
- Latency: raw sclk rise to dvalid is 4 mclk cycles (2 sync + edge detect + output register).

Test Plan:
- Reset release, MODE=0, mclk = 8x sclk, 32-bit slots, left=24'h00C491, right=24'hFFFFFF -> one dvalid per frame, ldata=24'h00C491, rdata=24'hFFFFFF, frame_err never asserted.
- OUT_WIDTH=32, DATA_WIDTH=24, left=24'h800001, right=24'h000000 -> ldata=32'hFF800001, rdata=32'h00000000.
- MODE=1, 24-bit slots, left=24'h0085C5, right=24'h123456 -> ldata=24'h0085C5, rdata=24'h123456. Also check that the same stream received with MODE=0 is off by one bit.
- 16-bit slots with DATA_WIDTH=24 for 3 frames -> 6 frame_err strobes, err_cnt=6, samples zero-padded in the low 8 bits, dvalid still once per frame.
- mute_l=1 during a frame with left=24'h7FFFFF -> ldata=0, rdata unaffected, led_l=1 one cycle after mute_l. Release mute -> the next frame shows the left sample.
- rst_n pulsed low mid-left-slot -> all outputs 0 immediately. First dvalid only after the next full left+right pair, carrying those values.
